param_arbiter: RTL and testbench

Parametrised N-way request arbiter with registered one-hot grant, selectable fixed-priority or round-robin policy, and grant locking with an optional maximum-hold limit. Generalises the team's 4-bit fixed-priority arbiter. Sits in front of any shared resource (bus, memory port, FIFO write side) where requesters hold `req` for the duration of their access.

---
 rtl/param_arbiter.sv | 171 +++++++++++++++++
 tb/tb_param_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/param_arbiter.sv
// -----------------------------------------------------------------------------
// param_arbiter
//
// Parametrised N-way request arbiter that sits in front of a shared resource.
// Every output is registered, so req has no combinational path to the outputs.
// The grant is either one-hot or all zero.
//
// Policies:
//   MODE 0 : fixed priority. The highest set index wins.
//   MODE 1 : round-robin. The search starts at ptr and wraps modulo N.
//
// Locking:
//   A holder keeps the grant for as long as its req stays high. When
//   MAX_HOLD != 0, the holder loses the grant after MAX_HOLD consecutive
//   cycles if any other requester is waiting. A sole requester keeps the
//   grant, and its hold count restarts at 1.
//
// Parameters:
//   N        : number of requesters, 2..32
//   MODE     : 0 = fixed priority, 1 = round-robin
//   MAX_HOLD : maximum consecutive contested grant cycles, 0 = unlimited
//
// Ports:
//   clk         : clock. All state changes on the rising edge.
//   rst         : asynchronous, active-high reset
//   req         : level-sensitive request vector, one bit per requester
//   grant       : registered one-hot grant, or all zero
//   grant_valid : registered OR of grant
//   grant_idx   : registered binary index of the granted bit, 0 when idle
// -----------------------------------------------------------------------------
module param_arbiter #(
   parameter int N        = 4,
   parameter int MODE     = 0,
   parameter int MAX_HOLD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IW = $clog2(N);
   // hold_cnt only needs to reach MAX_HOLD.
   // With an unlimited hold, a single saturating bit is enough.
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   // The two states are decoded from grant_valid. They are not stored separately.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } state_t;

   // Fixed priority pick. The result is {found, index}.
   // A later (higher) index overwrites an earlier one, so the highest set bit wins.
   function automatic logic [IW:0] f_pick_fixed(input logic [N-1:0] i_r);
      logic [IW:0] res;
      res = '0;
      for (int i = 0; i < N; i++) begin
         if (i_r[i]) res = {1'b1, IW'(i)};
      end
      return res;
   endfunction

   // Round-robin pick. The result is {found, index}.
   // The loop walks the search order backwards, so the last assignment is the
   // first set bit at or after i_start, wrapping modulo N.
   function automatic logic [IW:0] f_pick_rr(input logic [N-1:0]  i_r,
                                             input logic [IW-1:0] i_start);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(i_start) + k;
         if (idx >= N) idx = idx - N;
         if (i_r[idx]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   // Registered state
   logic [N-1:0]  r_grant;
   logic          r_grant_valid;
   logic [IW-1:0] r_grant_idx;
   logic [IW-1:0] r_ptr;
   logic [HW-1:0] r_hold_cnt;

   // Next-state logic
   state_t        w_state;
   logic [N-1:0]  w_holder_oh;
   logic          w_holder_req;
   logic          w_at_limit;
   logic          w_others_req;
   logic          w_keep;
   logic [N-1:0]  w_arb_req;
   logic [IW:0]   w_pick;
   logic [N-1:0]  w_grant_nxt;
   logic          w_valid_nxt;
   logic [IW-1:0] w_idx_nxt;
   logic [IW-1:0] w_ptr_nxt;
   logic [HW-1:0] w_hold_nxt;

   // NOTE: every signal gets a default at the top of the block. This way no
   // path through the ifs leaves a value unassigned, and no latch is inferred.
   always_comb begin
      w_state      = r_grant_valid ? ST_GRANTED : ST_IDLE;
      w_holder_oh  = N'(1) << r_grant_idx;
      w_holder_req = |(req & w_holder_oh);
      w_others_req = |(req & ~w_holder_oh);
      w_at_limit   = (MAX_HOLD != 0) && (r_hold_cnt == HW'(MAX_HOLD));
      w_keep       = (w_state == ST_GRANTED) && w_holder_req && !w_at_limit;

      // Expire case: the holder has reached MAX_HOLD.
      // If someone else is waiting, the holder is masked out.
      // If nobody else is waiting, the holder competes normally and wins again.
      // On release, the holder's req bit is already 0, so no mask is needed.
      w_arb_req = req;
      if ((w_state == ST_GRANTED) && w_holder_req && w_at_limit && w_others_req)
         w_arb_req = req & ~w_holder_oh;

      w_pick = (MODE == 1) ? f_pick_rr(w_arb_req, r_ptr) : f_pick_fixed(w_arb_req);

      w_grant_nxt = '0;
      w_valid_nxt = 1'b0;
      w_idx_nxt   = '0;
      w_hold_nxt  = '0;
      w_ptr_nxt   = r_ptr;

      if (w_keep) begin
         w_grant_nxt = r_grant;
         w_valid_nxt = 1'b1;
         w_idx_nxt   = r_grant_idx;
         // The count saturates. This only matters for an unlimited hold.
         // A bounded hold never counts past MAX_HOLD.
         w_hold_nxt  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
      end else if (w_pick[IW]) begin
         w_grant_nxt = N'(1) << w_pick[IW-1:0];
         w_valid_nxt = 1'b1;
         w_idx_nxt   = w_pick[IW-1:0];
         w_hold_nxt  = HW'(1);
         // The next search starts just after the winner.
         // Written out explicitly so that non-power-of-two N wraps correctly.
         if (MODE == 1)
            w_ptr_nxt = (w_pick[IW-1:0] == IW'(N - 1)) ? '0 : w_pick[IW-1:0] + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments. Every flop then
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant       <= '0;
         r_grant_valid <= 1'b0;
         r_grant_idx   <= '0;
         r_ptr         <= '0;
         r_hold_cnt    <= '0;
      end else begin
         r_grant       <= w_grant_nxt;
         r_grant_valid <= w_valid_nxt;
         r_grant_idx   <= w_idx_nxt;
         r_ptr         <= w_ptr_nxt;
         r_hold_cnt    <= w_hold_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_grant_valid;
   assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_param_arbiter.sv
// -----------------------------------------------------------------------------
// tb_param_arbiter
//
// Directed bench. Five arbiter instances share one clock and one reset:
//   u_fp  : N=4, fixed priority, unlimited hold
//   u_fl  : N=4, fixed priority, MAX_HOLD=2
//   u_rr1 : N=4, round-robin,    MAX_HOLD=1
//   u_rr3 : N=4, round-robin,    MAX_HOLD=3
//   u_n8  : N=8, round-robin,    unlimited hold
// Each instance has its own req vector. An instance's req is held at 0
// while other instances are being exercised.
// -----------------------------------------------------------------------------
module tb_param_arbiter;

   logic       clk;
   logic       rst;

   logic [3:0] req_fp, req_fl, req_rr1, req_rr3;
   logic [7:0] req_n8;

   logic [3:0] grant_fp, grant_fl, grant_rr1, grant_rr3;
   logic [7:0] grant_n8;
   logic       valid_fp, valid_fl, valid_rr1, valid_rr3, valid_n8;
   logic [1:0] idx_fp, idx_fl, idx_rr1, idx_rr3;
   logic [2:0] idx_n8;

   int n_checks = 0;
   int n_fails  = 0;

   param_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fp (
      .clk(clk), .rst(rst), .req(req_fp),
      .grant(grant_fp), .grant_valid(valid_fp), .grant_idx(idx_fp));

   param_arbiter #(.N(4), .MODE(0), .MAX_HOLD(2)) u_fl (
      .clk(clk), .rst(rst), .req(req_fl),
      .grant(grant_fl), .grant_valid(valid_fl), .grant_idx(idx_fl));

   param_arbiter #(.N(4), .MODE(1), .MAX_HOLD(1)) u_rr1 (
      .clk(clk), .rst(rst), .req(req_rr1),
      .grant(grant_rr1), .grant_valid(valid_rr1), .grant_idx(idx_rr1));

   param_arbiter #(.N(4), .MODE(1), .MAX_HOLD(3)) u_rr3 (
      .clk(clk), .rst(rst), .req(req_rr3),
      .grant(grant_rr3), .grant_valid(valid_rr3), .grant_idx(idx_rr3));

   param_arbiter #(.N(8), .MODE(1), .MAX_HOLD(0)) u_n8 (
      .clk(clk), .rst(rst), .req(req_n8),
      .grant(grant_n8), .grant_valid(valid_n8), .grant_idx(idx_n8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then wait 1 time unit so outputs are sampled
   // away from the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected grant sequences (hand-derived)
   logic [3:0] exp_fl  [6] = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
   logic [3:0] exp_rr1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [1:0] exp_rr3h[8] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};

   initial begin
      rst     = 1'b1;
      req_fp  = '0;
      req_fl  = '0;
      req_rr1 = '0;
      req_rr3 = '0;
      req_n8  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Reset state
      check("rst_grant_fp", 32'(grant_fp), 32'h0);
      check("rst_valid_fp", 32'(valid_fp), 32'h0);
      check("rst_idx_fp",   32'(idx_fp),   32'h0);
      check("rst_ptr_n8",   32'(u_n8.r_ptr), 32'h0);

      // Fixed priority: all four request, the highest index wins
      req_fp = 4'b1111;
      step();
      check("fp_all_grant", 32'(grant_fp), 32'h8);
      check("fp_all_idx",   32'(idx_fp),   32'd3);
      check("fp_all_valid", 32'(valid_fp), 32'h1);
      // Unlimited hold: the grant stays on index 3
      step();
      check("fp_lock_grant", 32'(grant_fp), 32'h8);
      // Holder drops: the grant hands over to index 2 with no idle cycle
      req_fp = 4'b0111;
      step();
      check("fp_hand_grant", 32'(grant_fp), 32'h4);
      check("fp_hand_valid", 32'(valid_fp), 32'h1);
      check("fp_hand_idx",   32'(idx_fp),   32'd2);

      // Asynchronous reset mid-cycle while grant = 0100
      #2;
      rst = 1'b1;
      #1;
      check("arst_grant", 32'(grant_fp), 32'h0);
      check("arst_valid", 32'(valid_fp), 32'h0);
      check("arst_idx",   32'(idx_fp),   32'h0);
      req_fp = '0;
      @(negedge clk);
      rst = 1'b0;
      step();
      check("post_rst_grant0", 32'(grant_fp), 32'h0);
      step();
      check("post_rst_grant1", 32'(valid_fp), 32'h0);

      // Fixed priority with MAX_HOLD=2: two requesters alternate every 2 cycles
      req_fl = 4'b1100;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("fl_seq%0d", i), 32'(grant_fl), 32'(exp_fl[i]));
      end
      // req fall to grant fall takes 1 cycle
      req_fl = '0;
      step();
      check("fl_drop_grant", 32'(grant_fl), 32'h0);
      check("fl_drop_idx",   32'(idx_fl),   32'h0);

      // Round-robin with MAX_HOLD=1: rotation and pointer wrap 3 -> 0
      req_rr1 = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("rr1_seq%0d", i), 32'(grant_rr1), 32'(exp_rr1[i]));
      end
      check("rr1_idx_wrap", 32'(idx_rr1), 32'd0);
      req_rr1 = '0;

      // Sole requester with MAX_HOLD=3: the grant never drops, the count restarts
      req_rr3 = 4'b0010;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("rr3_grant%0d", i), 32'(grant_rr3), 32'h2);
         check($sformatf("rr3_hold%0d", i),  32'(u_rr3.r_hold_cnt), 32'(exp_rr3h[i]));
      end
      req_rr3 = '0;

      // N=8 round-robin: first grant index 5 so that ptr becomes 6
      req_n8 = 8'b0010_0000;
      step();
      check("n8_g5",   32'(grant_n8),    32'h20);
      check("n8_ptr6", 32'(u_n8.r_ptr),  32'd6);
      req_n8 = '0;
      step();
      check("n8_idle",      32'(valid_n8),   32'h0);
      check("n8_idle_ptr6", 32'(u_n8.r_ptr), 32'd6);
      // The search runs 6, 7, 0, so index 0 wins over index 5
      req_n8 = 8'b0010_0001;
      step();
      check("n8_wrap_grant", 32'(grant_n8),   32'h01);
      check("n8_wrap_ptr1",  32'(u_n8.r_ptr), 32'd1);
      // Holder 0 releases: index 5 takes over immediately
      req_n8 = 8'b0010_0000;
      step();
      check("n8_hand_grant", 32'(grant_n8), 32'h20);
      check("n8_hand_idx",   32'(idx_n8),   32'd5);
      check("n8_hand_ptr6",  32'(u_n8.r_ptr), 32'd6);
      req_n8 = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
